// File: rtl/lovers_operand_loader.sv
// Operand loader for the binary-Edwards scalar-multiplication core: packs 32-bit words
// into WIDTH-bit operands, hands them to the core over load/ack, then serves the key MSB first.
`timescale 1ns/1ps
module lovers_operand_loader #(
    parameter int WIDTH   = 163,
    parameter int WORD    = 32,
    parameter int NUM_OPS = 4,
    parameter int WPO     = (WIDTH + WORD - 1) / WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic [WORD-1:0]  word_data,
    output logic [WIDTH-1:0] op_data,
    output logic [2:0]       op_index,
    output logic             op_load,
    input  logic             op_ack,
    output logic             ki,
    input  logic             next_key,
    output logic             key_ready,
    output logic             key_done,
    output logic             fmt_err,
    output logic             busy
);

    localparam int WC_W     = (WPO > 1) ? $clog2(WPO) : 1;
    localparam int BI_W     = $clog2(WIDTH);
    localparam int TOP_BITS = WIDTH - WORD * (WPO - 1);
    localparam int PAD_W    = WORD * WPO;

    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WPO - 1);
    localparam logic [2:0]      LAST_OP   = 3'(NUM_OPS - 1);
    localparam logic [BI_W-1:0] KEY_MSB   = BI_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_PUSH,
        S_WAIT_ACK,
        S_KEY
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [2:0]        op_cnt_q, op_cnt_d;
    logic [BI_W-1:0]   bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0]  asm_q, asm_d;
    logic [WIDTH-1:0]  key_q, key_d;
    logic              key_done_q, key_done_d;
    logic              fmt_err_q, fmt_err_d;
    logic              arm_q, arm_d;
    logic [PAD_W-1:0]  asm_wide;

    logic last_word;
    assign last_word = (word_cnt_q == LAST_WORD);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:     if (start && arm_q) state_d = S_COLLECT;
                S_COLLECT:  if (word_valid && last_word)
                                state_d = (op_cnt_q == LAST_OP) ? S_KEY : S_PUSH;
                S_PUSH:     state_d = S_WAIT_ACK;
                S_WAIT_ACK: if (op_ack) state_d = S_COLLECT;
                S_KEY:      if (next_key && bit_idx_q == '0) state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        word_ready = (state_q == S_COLLECT);
        op_load    = (state_q == S_PUSH);
        op_data    = '0;
        op_index   = '0;
        if (state_q == S_PUSH || state_q == S_WAIT_ACK) begin
            op_data  = asm_q;
            op_index = op_cnt_q;
        end
        key_ready  = (state_q == S_KEY);
        ki         = (state_q == S_KEY) ? key_q[bit_idx_q] : 1'b0;
        key_done   = key_done_q;
        fmt_err    = fmt_err_q;
        busy       = (state_q != S_IDLE);
    end

    // NOTE: every variable gets a default at the top so no path through the block infers a latch.
    always_comb begin
        word_cnt_d = word_cnt_q;
        op_cnt_d   = op_cnt_q;
        bit_idx_d  = bit_idx_q;
        asm_d      = asm_q;
        key_d      = key_q;
        key_done_d = key_done_q;
        fmt_err_d  = fmt_err_q;
        arm_d      = 1'b1;
        asm_wide   = PAD_W'(asm_q);

        if (abort) begin
            word_cnt_d = '0;
            op_cnt_d   = '0;
            bit_idx_d  = KEY_MSB;
            key_done_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && arm_q) begin
                        word_cnt_d = '0;
                        op_cnt_d   = '0;
                        bit_idx_d  = KEY_MSB;
                        key_done_d = 1'b0;
                        fmt_err_d  = 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (word_valid) begin
                        // Writing into a word-padded copy drops the unused top-word bits for free.
                        asm_wide[WORD*int'(word_cnt_q) +: WORD] = word_data;
                        asm_d = asm_wide[WIDTH-1:0];
                        if (last_word) begin
                            word_cnt_d = '0;
                            if (|word_data[WORD-1:TOP_BITS]) fmt_err_d = 1'b1;
                            if (op_cnt_q == LAST_OP) begin
                                key_d     = asm_d;
                                bit_idx_d = KEY_MSB;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end
                end
                S_WAIT_ACK: if (op_ack) op_cnt_d = op_cnt_q + 1'b1;
                S_KEY: begin
                    if (next_key) begin
                        if (bit_idx_q == '0) key_done_d = 1'b1;
                        else                 bit_idx_d  = bit_idx_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the wide assembly and key registers are reset too, so op_data and ki read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            op_cnt_q   <= '0;
            bit_idx_q  <= KEY_MSB;
            asm_q      <= '0;
            key_q      <= '0;
            key_done_q <= 1'b0;
            fmt_err_q  <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            word_cnt_q <= word_cnt_d;
            op_cnt_q   <= op_cnt_d;
            bit_idx_q  <= bit_idx_d;
            asm_q      <= asm_d;
            key_q      <= key_d;
            key_done_q <= key_done_d;
            fmt_err_q  <= fmt_err_d;
            arm_q      <= arm_d;
        end
    end

endmodule

// File: tb/tb_lovers_operand_loader.sv
// Randomised bench for lovers_operand_loader: drives whole jobs and compares every handshake
// against operands rebuilt from the word lists with plain shift/OR arithmetic.
`timescale 1ns/1ps
module tb_lovers_operand_loader;

    localparam int WIDTH   = 163;
    localparam int WORD    = 32;
    localparam int NUM_OPS = 4;
    localparam int WPO     = 6;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             word_valid;
    logic             word_ready;
    logic [WORD-1:0]  word_data;
    logic [WIDTH-1:0] op_data;
    logic [2:0]       op_index;
    logic             op_load;
    logic             op_ack;
    logic             ki;
    logic             next_key;
    logic             key_ready;
    logic             key_done;
    logic             fmt_err;
    logic             busy;

    int errors = 0;
    int checks = 0;

    logic [WORD-1:0] words [NUM_OPS][WPO];

    lovers_operand_loader #(
        .WIDTH(WIDTH), .WORD(WORD), .NUM_OPS(NUM_OPS), .WPO(WPO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .op_data(op_data), .op_index(op_index), .op_load(op_load), .op_ack(op_ack),
        .ki(ki), .next_key(next_key), .key_ready(key_ready), .key_done(key_done),
        .fmt_err(fmt_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference operand: OR together each word shifted to its position, then truncate.
    function automatic logic [WIDTH-1:0] build_operand(input int k);
        logic [WORD*WPO-1:0] acc;
        acc = '0;
        for (int j = 0; j < WPO; j++)
            acc = acc | ((WORD*WPO)'(words[k][j]) << (WORD * j));
        return acc[WIDTH-1:0];
    endfunction

    function automatic bit top_word_bad(input int k);
        return (words[k][WPO-1] >> 3) != '0;
    endfunction

    task automatic fill_words(input bit directed, input int bad_op, input logic [WORD-1:0] bad_val);
        for (int k = 0; k < NUM_OPS; k++) begin
            for (int j = 0; j < WPO; j++) begin
                if (directed)
                    words[k][j] = (j == WPO - 1) ? 32'h0000_0005 : 32'h1111_1111 * (j + 1);
                else
                    words[k][j] = (j == WPO - 1) ? {29'b0, 3'($urandom)} : 32'($urandom);
                if (k == bad_op && j == WPO - 1) words[k][j] = bad_val;
            end
        end
    endtask

    task automatic send_word(input logic [WORD-1:0] data);
        logic rdy;
        int   budget;
        word_valid = 1'b1;
        word_data  = data;
        budget     = 0;
        do begin
            rdy = word_ready;
            step();
            budget++;
        end while (!rdy && budget < 50);
        if (!rdy) check("word_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_job(input int ack_delay, input bit valid_always, input bit ack_in_push,
                           input bit pester, input int abort_op, input int rst_bit);
        logic [WIDTH-1:0] exp_op;
        bit               fmt_acc;
        fmt_acc = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("fmt_err_cleared", fmt_err, 1'b0);
        check("key_done_cleared", key_done, 1'b0);

        for (int k = 0; k < NUM_OPS; k++) begin
            for (int j = 0; j < WPO; j++) begin
                if (!valid_always) begin
                    repeat ($urandom_range(0, 2)) begin
                        word_valid = 1'b0;
                        start      = pester;
                        next_key   = pester;
                        step();
                        start    = 1'b0;
                        next_key = 1'b0;
                        check("collect_hold", word_ready, 1'b1);
                    end
                end
                send_word(words[k][j]);
            end
            if (!valid_always) word_valid = 1'b0;
            if (top_word_bad(k)) fmt_acc = 1'b1;
            exp_op = build_operand(k);

            if (k < NUM_OPS - 1) begin
                check("push_op_load", op_load, 1'b1);
                check("push_op_index", op_index, 3'(k));
                check("push_op_data", op_data, exp_op);
                check("push_word_ready", word_ready, 1'b0);
                check("push_fmt_err", fmt_err, fmt_acc);
                if (valid_always) word_data = words[k+1][0];
                op_ack = ack_in_push;
                step();
                op_ack = 1'b0;
                repeat (ack_delay) begin
                    check("wait_op_load", op_load, 1'b0);
                    check("wait_word_ready", word_ready, 1'b0);
                    check("wait_op_data", op_data, exp_op);
                    check("wait_op_index", op_index, 3'(k));
                    step();
                end
                check("wait_before_ack", word_ready, 1'b0);
                if (abort_op == k) begin
                    op_ack = 1'b1;
                    abort  = 1'b1;
                    step();
                    op_ack = 1'b0;
                    abort  = 1'b0;
                    word_valid = 1'b0;
                    check("abort_busy", busy, 1'b0);
                    check("abort_word_ready", word_ready, 1'b0);
                    check("abort_op_load", op_load, 1'b0);
                    check("abort_key_ready", key_ready, 1'b0);
                    check("abort_key_done", key_done, 1'b0);
                    check("abort_fmt_kept", fmt_err, fmt_acc);
                    step();
                    check("abort_stays_idle", busy, 1'b0);
                    return;
                end
                op_ack = 1'b1;
                step();
                op_ack = 1'b0;
                check("after_ack_ready", word_ready, 1'b1);
                check("after_ack_op_load", op_load, 1'b0);
            end else begin
                word_valid = 1'b0;
                check("key_ready", key_ready, 1'b1);
                check("key_word_ready", word_ready, 1'b0);
                check("key_fmt_err", fmt_err, fmt_acc);
                check("key_op_load", op_load, 1'b0);
                for (int i = WIDTH - 1; i >= 0; i--) begin
                    check("ki_bit", ki, exp_op[i]);
                    if (i == rst_bit) begin
                        #2 rst_n = 1'b0;
                        #1;
                        check("rst_ki", ki, 1'b0);
                        check("rst_key_ready", key_ready, 1'b0);
                        check("rst_busy", busy, 1'b0);
                        check("rst_fmt_err", fmt_err, 1'b0);
                        step();
                        rst_n = 1'b1;
                        start = 1'b1;
                        step();
                        start = 1'b0;
                        check("start_at_release_ignored", busy, 1'b0);
                        step();
                        return;
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        step();
                        check("ki_hold", ki, exp_op[i]);
                    end
                    next_key = 1'b1;
                    start    = pester;
                    step();
                    next_key = 1'b0;
                    start    = 1'b0;
                end
                check("done_key_done", key_done, 1'b1);
                check("done_key_ready", key_ready, 1'b0);
                check("done_ki", ki, 1'b0);
                check("done_busy", busy, 1'b0);
                step();
                check("key_done_sticky", key_done, 1'b1);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        op_ack     = 1'b0;
        next_key   = 1'b0;
        #12;
        check("rst_word_ready", word_ready, 1'b0);
        check("rst_op_load", op_load, 1'b0);
        check("rst_op_data", op_data, '0);
        check("rst_op_index", op_index, 3'd0);
        check("rst_ki", ki, 1'b0);
        check("rst_key_ready", key_ready, 1'b0);
        check("rst_key_done", key_done, 1'b0);
        check("rst_fmt_err", fmt_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        word_valid = 1'b1;
        step();
        check("idle_ignores_words", busy, 1'b0);
        word_valid = 1'b0;

        fill_words(1'b1, -1, '0);
        run_job(3, 1'b0, 1'b0, 1'b0, -1, -1);

        fill_words(1'b0, 1, 32'hFFFF_FFFF);
        run_job(2, 1'b0, 1'b0, 1'b0, -1, -1);

        fill_words(1'b0, -1, '0);
        run_job(10, 1'b1, 1'b1, 1'b0, -1, -1);

        fill_words(1'b0, 0, 32'($urandom) | 32'h8);
        run_job(2, 1'b0, 1'b0, 1'b0, 1, -1);
        fill_words(1'b0, -1, '0);
        run_job(1, 1'b0, 1'b0, 1'b0, -1, -1);

        fill_words(1'b0, -1, '0);
        run_job(1, 1'b0, 1'b0, 1'b0, -1, 80);
        fill_words(1'b0, -1, '0);
        run_job(2, 1'b0, 1'b0, 1'b1, -1, -1);

        for (int n = 0; n < 4; n++) begin
            fill_words(1'b0, $urandom_range(0, 5), 32'($urandom) | 32'h10);
            run_job($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lovers_operand_loader.md
Name: lovers_operand_loader

Overview:
- Upstream feeder for the binary-Edwards scalar-multiplication core.
- Accepts a stream of 32-bit words and assembles them into 163-bit field-element operands.
- Pushes each operand to the core over a load/ack handshake.
- Holds the final operand locally as the scalar key and serves it bit-serially (MSB first) on the core's ki/next_key interface.

Parameters:
- WIDTH, 163, field-element and key width in bits.
- WORD, 32, input word width.
- NUM_OPS, 4, total operands per job: NUM_OPS-1 field elements, then 1 key. Legal range 2..8.
- WPO, 6, words per operand, equal to ceil(WIDTH/WORD).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a job; honoured only in IDLE.
- abort  in  1  synchronous return to IDLE from any state.
- word_valid  in  1  input word valid.
- word_ready  out  1  loader accepts a word this cycle.
- word_data  in  32  operand word, least-significant word first.
- op_data  out  163  assembled operand driven to the core.
- op_index  out  3  operand number, 0..NUM_OPS-2.
- op_load  out  1  one-cycle pulse: op_data/op_index valid.
- op_ack  in  1  core has captured the operand.
- ki  out  1  current key bit.
- next_key  in  1  core request to advance to the next key bit.
- key_ready  out  1  key loaded; ki valid.
- key_done  out  1  all WIDTH key bits consumed; sticky until start or abort.
- fmt_err  out  1  sticky: a top word carried nonzero bits [31:3].
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0. State IDLE. word_cnt=0, op_cnt=0, bit_idx=WIDTH-1. Assembly register and key register cleared.
- IDLE:
  - start=1 → COLLECT; clears word_cnt, op_cnt, key_done and fmt_err.
  - word_valid is ignored in IDLE (word_ready=0).
- COLLECT:
  - word_ready=1. A transfer occurs when word_valid&&word_ready.
  - Each transfer writes word_data into assembly bits [32*word_cnt +: 32], then word_cnt++.
  - On the word with word_cnt=WPO-1, only bits [2:0] are kept; any nonzero bit in [31:3] sets fmt_err. The job is not halted.
  - After word WPO-1, word_cnt returns to 0:
    - if op_cnt<NUM_OPS-1 → PUSH;
    - else the assembly register is copied to the key register, bit_idx=WIDTH-1 → KEY.
- PUSH:
  - Exactly one cycle. op_load=1, op_data=assembly[162:0], op_index=op_cnt.
  - Always → WAIT_ACK.
  - word_ready=0.
- WAIT_ACK:
  - op_data and op_index are held stable. op_ack is sampled only in this state; an ack arriving in the PUSH cycle is ignored.
  - On op_ack: op_cnt++ → COLLECT. The next word can be accepted on the following cycle.
  - There is no timeout.
- KEY:
  - key_ready=1, ki=key[bit_idx], word_ready=0.
  - On next_key with bit_idx>0: bit_idx--, and ki updates on the next cycle.
  - On next_key with bit_idx=0: key_done=1, key_ready=0, ki=0 → IDLE.
  - next_key outside KEY is ignored.
- abort:
  - Has priority over every other event, including a simultaneous start, word transfer or ack.
  - Next cycle: IDLE, counters reset, op_load/key_ready/ki=0, key_done=0.
  - fmt_err is retained until the next start.
- op_load never asserts twice for the same op_index.
- word_ready is combinational from state only; it never depends on word_valid.
- Asynchronous rst_n mid-job returns everything to reset values immediately.

Test Plan:
- Single job, NUM_OPS=4, words 0x11111111..0x00000005 per operand, op_ack 3 cycles after each op_load → op_index sequence 0,1,2 with op_data[162:160]=3'b101. Then key_ready=1, and 163 next_key pulses reproduce the key MSB→LSB on ki; key_done=1 after the last pulse.
- Top word 0xFFFFFFFF on operand 1 → op_data[162:160]=3'b111, fmt_err=1, job completes normally, fmt_err clears on the next start.
- word_valid held high continuously and op_ack delayed 10 cycles → word_ready=0 throughout PUSH/WAIT_ACK, no word lost. An op_ack pulsed in the PUSH cycle is ignored.
- abort asserted in WAIT_ACK of operand 1 together with op_ack → next cycle IDLE, busy=0, op_cnt=0; a restart reloads from op_index 0.
- rst_n dropped while in KEY with bit_idx=80 → immediate ki=0, key_ready=0, busy=0. A start in the same cycle reset releases is ignored.
- start pulse while busy, and next_key in COLLECT → no state change, no bit_idx change.
